div_unit: RTL and testbench

Iterative radix-2 divider for DIV/DIVU in the EX stage, beside the HI/LO/CP0 unit. EX launches an operation with `start`. The unit raises `busy` so the hazard unit stalls the pipeline. On completion it pulses `done`, and the HI/LO block captures `quotient` into LO and `remainder` into HI on that cycle.

---
 rtl/div_unit_if.sv | 26 ++
 rtl/div_unit.sv | 134 +++++++++++++
 tb/tb_div_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Bundles the EX-stage launch request and the divider result/handshake signals.
// The master is the EX/HI-LO side; the slave is div_unit.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor, cancel,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor, cancel,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU (fixed WIDTH+1 cycle latency).
// Define DIV_EARLY_OUT_EN to let divide-by-zero and |dividend| < |divisor| skip the iteration.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] count;
  logic             done_r;
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_raw;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dz_r;
  logic             accept;
  logic             early;
  logic             last_step;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return neg ? $unsigned(-sv) : v;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return cond_neg(v, sgn & v[WIDTH-1]);
  endfunction

  always_comb begin
    accept    = ((state == IDLE) || (state == DONE)) && bus.start && !bus.cancel;
    last_step = (count == CNT_W'(WIDTH - 1));
    rem_shift = {rem_acc, quo_sh[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs_mag};
`ifdef DIV_EARLY_OUT_EN
    early     = (count == '0) && ((dvs_mag == '0) || (quo_sh < dvs_mag));
`else
    early     = 1'b0;
`endif
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = CALC;
      CALC:    if (early || last_step) state_n = FIX;
      FIX:     state_n = DONE;
      DONE:    state_n = accept ? CALC : IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.cancel) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      done_r <= 1'b0;
      count  <= '0;
    end else begin
      state  <= state_n;
      done_r <= (state_n == DONE);
      if (accept)
        count <= '0;
      else if (state == CALC)
        count <= count + 1'b1;
    end
  end

  // Operand capture and one restoring step per CALC cycle; quo_sh shifts dividend bits out
  // while quotient bits shift in behind them.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_raw <= bus.dividend;
      dvs_mag <= magnitude(bus.divisor, bus.is_signed);
      quo_sh  <= magnitude(bus.dividend, bus.is_signed);
      rem_acc <= '0;
      neg_q   <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      neg_r   <= bus.is_signed & bus.dividend[WIDTH-1];
    end else if (state == CALC) begin
      if (early) begin
        // Trivial case: quotient 0, remainder is the whole dividend magnitude.
        quo_sh  <= '0;
        rem_acc <= quo_sh;
      end else if (!diff[WIDTH]) begin
        rem_acc <= diff[WIDTH-1:0];
        quo_sh  <= {quo_sh[WIDTH-2:0], 1'b1};
      end else begin
        rem_acc <= rem_shift[WIDTH-1:0];
        quo_sh  <= {quo_sh[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fix-up; results persist until the next completed FIX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient_r  <= '0;
      remainder_r <= '0;
      dz_r        <= 1'b0;
    end else if ((state == FIX) && !bus.cancel) begin
      if (dvs_mag == '0) begin
        quotient_r  <= '1;
        remainder_r <= dvd_raw;
        dz_r        <= 1'b1;
      end else begin
        quotient_r  <= cond_neg(quo_sh, neg_q);
        remainder_r <= cond_neg(rem_acc, neg_r);
        dz_r        <= 1'b0;
      end
    end
  end

  assign bus.busy        = (state == CALC) || (state == FIX);
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dz_r;

  logic unused_one;
  assign unused_one = ^ONE_W;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random operations against
// an arithmetic reference model (results, latency, busy duration, cancel, reset).
module tb_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] absval(input logic [W-1:0] v, input bit s);
    if (s && v[W-1]) return -v;
    return v;
  endfunction

  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    dz = (b == 0);
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
`ifdef DIV_EARLY_OUT_EN
    if (b == 0 || absval(a, s) < absval(b, s)) return 2;
`endif
    return 33;
  endfunction

  // Called #1 after an edge; leaves the bench #1 after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = bus.busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
      if (bus.busy) bcnt++;
    end
    if (!bus.done) lat = 999;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    logic [W-1:0] q, r;
    logic dz;
    int lat, bcnt;
    ref_div(a, b, s, q, r, dz);
    issue(a, b, s);
    wait_done(lat, bcnt);
    check({tag, "_lat"}, 64'(lat), 64'(exp_latency(a, b, s)));
    check({tag, "_busy"}, 64'(bcnt), 64'(exp_latency(a, b, s)));
    check({tag, "_q"}, 64'(bus.quotient), 64'(q));
    check({tag, "_r"}, 64'(bus.remainder), 64'(r));
    check({tag, "_dz"}, 64'(bus.div_by_zero), 64'(dz));
  endtask

  initial begin
    logic [W-1:0] a, b, q, r, q_prev, r_prev;
    logic dz;
    int lat, bcnt, mode;
    bit s;

    bus.start = 0; bus.is_signed = 0; bus.dividend = 0; bus.divisor = 0; bus.cancel = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_q", 64'(bus.quotient), 64'd0);
    check("reset_r", 64'(bus.remainder), 64'd0);
    check("reset_dz", 64'(bus.div_by_zero), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("divu_100_7", 32'd100, 32'd7, 1'b0);
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(bus.done), 64'd0);
    check("hold_q_idle", 64'(bus.quotient), 64'd14);
    run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op("div_5_0", 32'd5, 32'd0, 1'b1);
    run_op("divu_5_0", 32'd5, 32'd0, 1'b0);
    run_op("divu_3_9", 32'd3, 32'd9, 1'b0);
    run_op("div_m3_9", 32'hFFFF_FFFD, 32'd9, 1'b1);

    // Cancel at cycle 10: back to idle, no done, previous results kept.
    q_prev = bus.quotient;
    r_prev = bus.remainder;
    issue(32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    check("cancel_busy", 64'(bus.busy), 64'd0);
    check("cancel_done", 64'(bus.done), 64'd0);
    dz = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dz = 1'b1;
    end
    check("cancel_no_done", 64'(dz), 64'd0);
    check("cancel_hold_q", 64'(bus.quotient), 64'(q_prev));
    check("cancel_hold_r", 64'(bus.remainder), 64'(r_prev));
    run_op("after_cancel", 32'd1000, 32'd3, 1'b0);

    // Back-to-back: start held through the DONE cycle.
    issue(32'd77, 32'd5, 1'b0);
    wait_done(lat, bcnt);
    check("b2b_first_lat", 64'(lat), 64'd33);
    check("b2b_first_q", 64'(bus.quotient), 64'd15);
    bus.dividend = 32'hFFFF_FF9C;
    bus.divisor  = 32'd7;
    bus.is_signed = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b_done_drop", 64'(bus.done), 64'd0);
    check("b2b_busy_rise", 64'(bus.busy), 64'd1);
    wait_done(lat, bcnt);
    check("b2b_spacing", 64'(lat + 1), 64'd34);
    ref_div(32'hFFFF_FF9C, 32'd7, 1'b1, q, r, dz);
    check("b2b_second_q", 64'(bus.quotient), 64'(q));
    check("b2b_second_r", 64'(bus.remainder), 64'(r));

    // Asynchronous reset mid-CALC.
    issue(32'd123456, 32'd789, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_q", 64'(bus.quotient), 64'd0);
    check("arst_r", 64'(bus.remainder), 64'd0);
    check("arst_dz", 64'(bus.div_by_zero), 64'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int n = 0; n < 24; n++) begin
      mode = $urandom_range(0, 5);
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case (mode)
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: begin b = $urandom_range(100, 100000); a = $urandom_range(0, 99); end
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
        default: ;
      endcase
      run_op($sformatf("rnd%0d", n), a, b, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
